serial_addsub: RTL and testbench

//  Multi-cycle add/subtract unit. Reuses one BITS_PER_CYCLE-wide full-adder slice and a carry

---
 rtl/serial_addsub.sv | 126 ++++++++++++
 tb/tb_serial_addsub.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: one BITS_PER_CYCLE-wide full-adder slice reused LSB-first
// over WIDTH/BITS_PER_CYCLE cycles, with start/busy/done handshake and held results.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request sampled only in IDLE or DONE (accepted at that rising
  // edge); busy is high for exactly N cycles afterwards; done pulses for one cycle with
  // S/CO/OV valid from that cycle; start while busy is dropped, never queued.

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load, step, last;

  logic [WIDTH-1:0]        a_sh, b_sh, res_sh, res_nxt;
  logic                    carry;
  logic [CW-1:0]           count;
  logic [BITS_PER_CYCLE-1:0] sum;
  logic [BITS_PER_CYCLE:0]   c;

  assign last = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ripple slice over the low bits of the shift registers; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sum[i]   = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
  end

  // New sum bits enter at the MSB end so the result is aligned after N steps.
  assign res_nxt = (res_sh >> BITS_PER_CYCLE) |
                   (WIDTH'(sum) << (WIDTH - BITS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      S      <= '0;
      CO     <= 1'b0;
      OV     <= 1'b0;
    end else if (load) begin
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{SUB}};
      carry <= SUB ? 1'b1 : CI;
      count <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> BITS_PER_CYCLE;
      b_sh   <= b_sh >> BITS_PER_CYCLE;
      res_sh <= res_nxt;
      carry  <= c[BITS_PER_CYCLE];
      count  <= count + CW'(1);
      if (last) begin
        S  <= res_nxt;
        CO <= c[BITS_PER_CYCLE];
        OV <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases on 8-bit instances (1 and 4 bits/cycle) and a
// randomized scoreboard sweep on 16-bit instances (1, 2, 4, 16 bits/cycle).
module tb_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic rst_sw_n;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {co, ov, s[15:0]} for a w-bit operation.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sub);
    longint mask, ua, ub, sa, sb, full, sres, lim;
    logic co, ov;
    logic [15:0] s;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= lim) ? ua - (mask + 1) : ua;
    sb   = (ub >= lim) ? ub - (mask + 1) : ub;
    if (sub) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(ci);
      co   = (full > mask);
      sres = sa + sb + longint'(ci);
    end
    ov = (sres < -lim) || (sres > lim - 1);
    s  = 16'(full & mask);
    return {co, ov, s};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- 8-bit, 1 bit/cycle DUT ----------------
  logic       start8, ci8, sub8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, s8;
  logic [1:0] st8;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .CI(ci8), .SUB(sub8),
    .busy(busy8), .done(done8), .S(s8), .CO(co8), .OV(ov8), .state_dbg(st8)
  );

  // ---------------- 8-bit, 4 bits/cycle DUT ----------------
  logic       start4, ci4, sub4, busy4, done4, co4, ov4;
  logic [7:0] a4, b4, s4;
  logic [1:0] st4;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .CI(ci4), .SUB(sub4),
    .busy(busy4), .done(done4), .S(s4), .CO(co4), .OV(ov4), .state_dbg(st4)
  );

  // ---------------- driver tasks (8/1 instance) ----------------
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    @(negedge clk);
    a8 = a; b8 = b; ci8 = ci; sub8 = sub; start8 = 1'b1;
  endtask

  // Counts cycles after acceptance until done; hold keeps start high and scrambles operands.
  task automatic wait8(input bit hold, input logic [7:0] prev_s, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end else if (lat == 1) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
      end
      if (lat == 1) check("prev_result_held", s8, prev_s);
      if (busy8) nbusy++;
    end while (!done8 && lat < 40);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sub, input logic [17:0] exp);
    int lat, nb;
    logic [7:0] prev;
    prev = s8;
    issue8(a, b, ci, sub);
    wait8(1'b0, prev, lat, nb);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busy"}, nb, 8);
    check({tag, "_res"}, {co8, ov8, s8}, {exp[17:16], exp[7:0]});
  endtask

  // ---------------- 16-bit scoreboard sweep ----------------
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    logic        start, ci, sub, busy, done, co, ov, fin;
    logic [15:0] a, b, s;
    logic [1:0]  st;
    logic [17:0] exp_q[$];

    serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(BPC)) u_dut (
      .clk(clk), .rst_n(rst_sw_n), .start(start), .A(a), .B(b), .CI(ci), .SUB(sub),
      .busy(busy), .done(done), .S(s), .CO(co), .OV(ov), .state_dbg(st)
    );

    initial begin
      fin = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      wait (rst_sw_n === 1'b1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 150; i++) begin
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        a = pick16(); b = pick16(); ci = 1'($urandom); sub = 1'($urandom); start = 1'b1;
        exp_q.push_back(ref_op(16, a, b, ci, sub));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      check($sformatf("sweep%0d_drain", BPC), exp_q.size(), 0);
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (done) begin
        if (exp_q.size() == 0) check($sformatf("sweep%0d_spurious_done", BPC), 1, 0);
        else check($sformatf("sweep%0d_res", BPC), {co, ov, s}, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, nb, ndone;
    logic [7:0]  ra, rb;
    logic        rc, rs;
    logic [17:0] e;

    rst_n = 1'b0; rst_sw_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy8, done8, s8, co8, ov8, st8}, '0);
    rst_n = 1'b1; rst_sw_n = 1'b1;

    // basic add, carry/overflow corners, subtraction
    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h00, 8'h10});
    run8("add_ff_01_ci", 8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00, 8'h01});
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00, 8'h80});
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'h00, 8'hFE});
    run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h00, 8'h7F});

    repeat (5) @(negedge clk);
    check("idle_hold", {co8, ov8, s8}, {1'b1, 1'b1, 8'h7F});

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e = ref_op(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
      run8($sformatf("rand8_%0d", i), ra, rb, rc, rs, e);
    end

    // start held through RUN is ignored; start in DONE is accepted back-to-back
    issue8(8'h01, 8'h02, 1'b0, 1'b0);
    wait8(1'b1, s8, lat, nb);
    check("hold_busy", nb, 8);
    check("hold_res", {co8, ov8, s8}, {1'b0, 1'b0, 8'h03});
    a8 = 8'h30; b8 = 8'h05; ci8 = 1'b0; sub8 = 1'b1;
    wait8(1'b0, 8'h03, lat, nb);
    check("b2b_lat", lat, 9);
    check("b2b_res", {co8, ov8, s8}, {1'b1, 1'b0, 8'h2B});

    // 4 bits per cycle
    @(negedge clk);
    a4 = 8'hFF; b4 = 8'h01; ci4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      start4 = 1'b0;
      if (busy4) nb++;
    end while (!done4 && lat < 40);
    check("bpc4_lat", lat, 3);
    check("bpc4_busy", nb, 2);
    check("bpc4_res", {co4, ov4, s4}, {1'b1, 1'b0, 8'h00});

    // reset mid-operation discards the op
    issue8(8'h12, 8'h34, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset", {busy8, done8, s8, co8, ov8}, '0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("no_done_after_reset", ndone, 0);

    for (int k = 0; k < 20000 && !(sw[0].fin && sw[1].fin && sw[2].fin && sw[3].fin); k++)
      @(negedge clk);
    check("sweep_complete", {sw[0].fin, sw[1].fin, sw[2].fin, sw[3].fin}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
